// File: rtl/accel_sched_pkg.sv
// Shared constants and types for the CV-X-IF accelerator offload scheduler.
package accel_sched_pkg;
  localparam int SCHED_XLEN = 32;
  localparam int SCHED_ID_W = 4;
  localparam logic [6:0] CUSTOM0_OPC = 7'b0001011;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} sched_state_e;

  typedef struct packed {
    logic [SCHED_ID_W-1:0] id;
    logic [9:0]            funct;
    logic [SCHED_XLEN-1:0] rs1;
    logic [SCHED_XLEN-1:0] rs2;
    logic                  committed;
  } entry_t;

  function automatic logic is_custom0(input logic [6:0] opcode);
    return opcode == CUSTOM0_OPC;
  endfunction
endpackage

// File: rtl/accel_sched_queue.sv
// Ordered pending-instruction queue: id-search commit/kill with in-order
// compaction, head peek/pop, flush and a full flag.
module accel_sched_queue
  import accel_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enq_i,
  input  entry_t                enq_entry_i,
  input  logic                  commit_valid_i,
  input  logic [SCHED_ID_W-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  flush_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic                  head_valid_o,
  output logic                  full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t           slots_q [DEPTH];
  entry_t           slots_d [DEPTH];
  entry_t           work    [DEPTH];
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    work    = slots_q;
    slots_d = slots_q;
    keep    = '0;
    wr      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = CW'(i) < count_q;
      if (enq_i && CW'(i) == count_q) begin
        work[i] = enq_entry_i;
        keep[i] = 1'b1;
      end
      // The new entry is visible to the search, so a same-cycle commit lands on it.
      if (keep[i] && commit_valid_i && work[i].id == commit_id_i) begin
        if (commit_kill_i) keep[i] = 1'b0;
        else               work[i].committed = 1'b1;
      end
    end
    if (pop_i) keep[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        slots_d[wr[AW-1:0]] = work[i];
        wr = wr + CW'(1);
      end
    end
    count_d = flush_i ? '0 : wr;
  end

  // NOTE: only the occupancy count is reset; slot contents beyond the count are
  // never read, so the storage array carries no reset.
  always_ff @(posedge clk_i) begin
    slots_q <= slots_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign head_o       = slots_q[0];
  assign head_valid_o = count_q != '0;
  assign full_o       = count_q == CW'(DEPTH);
endmodule

// File: rtl/accel_offload_sched.sv
// CV-X-IF offload scheduler for one multi-cycle accelerator: queue, start on commit, return result.
// Optional ACCEL_SCHED_PERF_EN adds saturating perf_ops_o / perf_stall_o counters.
module accel_offload_sched
  import accel_sched_pkg::*;
#(
  parameter int XLEN  = SCHED_XLEN,
  parameter int ID_W  = SCHED_ID_W,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  output logic            issue_accept_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  input  logic            flush_i,
  output logic            acc_start_o,
  output logic [9:0]      acc_funct_o,
  output logic [XLEN-1:0] acc_a_o,
  output logic [XLEN-1:0] acc_b_o,
  input  logic            acc_done_i,
  input  logic [XLEN-1:0] acc_result_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [XLEN-1:0] result_data_o
`ifdef ACCEL_SCHED_PERF_EN
 ,output logic [31:0]     perf_ops_o,
  output logic [31:0]     perf_stall_o
`endif
);
  sched_state_e    state_q;
  logic            discard_q;
  logic [ID_W-1:0] op_id_q;
  entry_t          enq_entry;
  entry_t          head;
  logic            head_valid;
  logic            full;
  logic            enq;
  logic            launch;
  logic            unused_instr;

  assign unused_instr   = ^{issue_instr_i[24:15], issue_instr_i[11:7]};
  assign issue_ready_o  = !full;
  assign issue_accept_o = issue_valid_i && is_custom0(issue_instr_i[6:0]);
  assign enq            = issue_accept_o && issue_ready_o && !flush_i;

  assign enq_entry = '{id:        issue_id_i,
                       funct:     {issue_instr_i[31:25], issue_instr_i[14:12]},
                       rs1:       issue_rs1_i,
                       rs2:       issue_rs2_i,
                       committed: 1'b0};

  // Launching straight out of a RESP handshake gives back-to-back starts.
  assign launch = head_valid && head.committed && !flush_i &&
                  (state_q == IDLE || (state_q == RESP && result_ready_i));

  accel_sched_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enq_i          (enq),
    .enq_entry_i    (enq_entry),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .flush_i        (flush_i),
    .pop_i          (launch),
    .head_o         (head),
    .head_valid_o   (head_valid),
    .full_o         (full)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      discard_q      <= 1'b0;
      op_id_q        <= '0;
      acc_start_o    <= 1'b0;
      acc_funct_o    <= '0;
      acc_a_o        <= '0;
      acc_b_o        <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
    end else begin
      acc_start_o <= 1'b0;
      if (launch) begin
        acc_start_o <= 1'b1;
        acc_funct_o <= head.funct;
        acc_a_o     <= head.rs1;
        acc_b_o     <= head.rs2;
        op_id_q     <= head.id;
        discard_q   <= 1'b0;
      end
      case (state_q)
        IDLE: if (launch) state_q <= START;
        START: begin
          state_q <= WAIT;
          if (flush_i) discard_q <= 1'b1;
        end
        WAIT: begin
          if (acc_done_i) begin
            // A flushed op still has to finish; its result is simply dropped.
            if (discard_q || flush_i) begin
              state_q <= IDLE;
            end else begin
              result_valid_o <= 1'b1;
              result_id_o    <= op_id_q;
              result_data_o  <= acc_result_i;
              state_q        <= RESP;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        RESP: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            state_q        <= launch ? START : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ACCEL_SCHED_PERF_EN
  logic [31:0] ops_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == RESP && result_ready_i && ops_q != '1) ops_q <= ops_q + 32'd1;
      if (issue_valid_i && !issue_ready_o && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops_o   = ops_q;
  assign perf_stall_o = stall_q;
`endif
endmodule

// File: tb/tb_accel_offload_sched.sv
// Scoreboard bench for accel_offload_sched with a fixed-latency adder accelerator model.
module tb_accel_offload_sched;
  localparam int LAT = 3;

  typedef struct {
    logic [9:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
  } start_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic        issue_accept_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        flush_i;
  logic        acc_start_o;
  logic [9:0]  acc_funct_o;
  logic [31:0] acc_a_o;
  logic [31:0] acc_b_o;
  logic        acc_done_i;
  logic [31:0] acc_result_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;

  int     total = 0;
  int     bad   = 0;
  start_t exp_start[$];
  res_t   exp_res[$];

  logic        acc_busy = 1'b0;
  int          acc_cnt  = 0;
  logic [31:0] acc_sum, m_a, m_b;
  logic        stale_req = 1'b0;
  start_t      mdl_s;
  res_t        mon_r;

  always #5 clk = ~clk;

  accel_offload_sched dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_instr_i  (issue_instr_i),
    .issue_id_i     (issue_id_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_accept_o (issue_accept_o),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .flush_i        (flush_i),
    .acc_start_o    (acc_start_o),
    .acc_funct_o    (acc_funct_o),
    .acc_a_o        (acc_a_o),
    .acc_b_o        (acc_b_o),
    .acc_done_i     (acc_done_i),
    .acc_result_i   (acc_result_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o)
  );

  // Accelerator model: returns a+b, done LAT cycles after the start pulse.
  always @(negedge clk) begin
    acc_done_i = 1'b0;
    if (rst_i) begin
      acc_busy = 1'b0;
    end else begin
      if (stale_req) begin
        acc_done_i   = 1'b1;
        acc_result_i = 32'hdead_beef;
        stale_req    = 1'b0;
      end
      if (acc_busy) begin
        if (acc_cnt == 0) begin
          acc_done_i   = 1'b1;
          acc_result_i = acc_sum;
          acc_busy     = 1'b0;
          total++;
          if (acc_a_o !== m_a || acc_b_o !== m_b) begin
            bad++;
            $display("FAIL operand_hold: got a=%0d b=%0d, required a=%0d b=%0d", acc_a_o, acc_b_o, m_a, m_b);
          end
        end else begin
          acc_cnt--;
        end
      end
      if (acc_start_o) begin
        total++;
        if (exp_start.size() == 0) begin
          bad++;
          $display("FAIL start_unexpected: got start funct=%h a=%0d b=%0d, required no start", acc_funct_o, acc_a_o, acc_b_o);
          m_a = acc_a_o;
          m_b = acc_b_o;
        end else begin
          mdl_s = exp_start.pop_front();
          if (acc_funct_o !== mdl_s.funct || acc_a_o !== mdl_s.a || acc_b_o !== mdl_s.b) begin
            bad++;
            $display("FAIL start_operands: got funct=%h a=%0d b=%0d, required funct=%h a=%0d b=%0d",
                     acc_funct_o, acc_a_o, acc_b_o, mdl_s.funct, mdl_s.a, mdl_s.b);
          end
          m_a = mdl_s.a;
          m_b = mdl_s.b;
        end
        acc_sum  = m_a + m_b;
        acc_busy = 1'b1;
        acc_cnt  = LAT - 1;
      end
    end
  end

  // Result monitor: every handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      total++;
      if (exp_res.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got id=%0d data=%0d, required none", result_id_o, result_data_o);
      end else begin
        mon_r = exp_res.pop_front();
        if (result_id_o !== mon_r.id || result_data_o !== mon_r.data) begin
          bad++;
          $display("FAIL result_data: got id=%0d data=%0d, required id=%0d data=%0d",
                   result_id_o, result_data_o, mon_r.id, mon_r.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  task automatic push_op(input logic [9:0] funct, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id, input logic with_res);
    start_t s;
    res_t   r;
    s.funct = funct;
    s.a     = a;
    s.b     = b;
    exp_start.push_back(s);
    if (with_res) begin
      r.id   = id;
      r.data = a + b;
      exp_res.push_back(r);
    end
  endtask

  task automatic issue_op(input string name, input logic [31:0] instr, input logic [3:0] id,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic exp_ready, input logic exp_accept, input logic with_commit);
    issue_valid_i  = 1'b1;
    issue_instr_i  = instr;
    issue_id_i     = id;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
    commit_valid_i = with_commit;
    commit_id_i    = id;
    commit_kill_i  = 1'b0;
    #1;
    total++;
    if (issue_ready_o !== exp_ready) begin
      bad++;
      $display("FAIL %s_ready: got %0b, required %0b", name, issue_ready_o, exp_ready);
    end
    if (exp_ready) begin
      total++;
      if (issue_accept_o !== exp_accept) begin
        bad++;
        $display("FAIL %s_accept: got %0b, required %0b", name, issue_accept_o, exp_accept);
      end
    end
    @(posedge clk); #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic commit_op(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    @(posedge clk); #1;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic flush_cycle();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic wait_results(input string name);
    int k = 0;
    while ((exp_res.size() != 0 || exp_start.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (k >= 100) begin
      bad++;
      $display("FAIL %s_drain: timeout with results=%0d starts=%0d pending, required 0", name, exp_res.size(), exp_start.size());
    end
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    while (!acc_start_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (k >= 20) begin
      bad++;
      $display("FAIL %s_start: timeout, got no acc_start_o, required a start", name);
    end
  endtask

  task automatic quiet_window(input string name, input int cycles);
    logic seen_start = 1'b0;
    logic seen_res   = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      seen_start |= acc_start_o;
      seen_res   |= result_valid_o;
    end
    total++;
    if (seen_start !== 1'b0 || seen_res !== 1'b0) begin
      bad++;
      $display("FAIL %s_quiet: got start=%0b result_valid=%0b, required 0 0", name, seen_start, seen_res);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (issue_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b, required 1", issue_ready_o);
    end
    total++;
    if ({acc_start_o, result_valid_o, issue_accept_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got start/valid/accept=%b, required 000", {acc_start_o, result_valid_o, issue_accept_o});
    end
    total++;
    if (acc_funct_o !== '0 || acc_a_o !== '0 || acc_b_o !== '0 || result_id_o !== '0 || result_data_o !== '0) begin
      bad++;
      $display("FAIL reset_data: got funct=%h a=%h b=%h id=%h data=%h, required all 0",
               acc_funct_o, acc_a_o, acc_b_o, result_id_o, result_data_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    int k = 0;
    issue_op("single", mk_instr(7'h05, 3'h2, 7'b0001011), 4'd3, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    push_op({7'h05, 3'h2}, 32'd5, 32'd7, 4'd3, 1'b1);
    commit_op(4'd3, 1'b0);
    total++;
    if (acc_start_o !== 1'b0) begin
      bad++;
      $display("FAIL single_early_start: got %0b, required 0", acc_start_o);
    end
    @(posedge clk); #1;
    total++;
    if (acc_start_o !== 1'b1) begin
      bad++;
      $display("FAIL single_start_latency: got %0b, required 1", acc_start_o);
    end
    while (!result_valid_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (k != LAT + 1) begin
      bad++;
      $display("FAIL single_result_latency: got %0d cycles, required %0d", k, LAT + 1);
    end
    wait_results("single");
  endtask

  task automatic test_non_accel();
    issue_op("nonacc", mk_instr(7'h00, 3'h0, 7'b0110011), 4'd6, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    commit_op(4'd6, 1'b0);
    quiet_window("nonacc", 6);
  endtask

  task automatic test_full();
    int k = 0;
    for (int i = 1; i <= 4; i++)
      issue_op("full_fill", mk_instr(7'h11, 3'h1, 7'b0001011), 4'(i), 32'(10 * i), 32'(i), 1'b1, 1'b1, 1'b0);
    issue_op("full_fifth", mk_instr(7'h11, 3'h1, 7'b0001011), 4'd5, 32'd50, 32'd5, 1'b0, 1'b1, 1'b0);
    push_op({7'h11, 3'h1}, 32'd10, 32'd1, 4'd1, 1'b1);
    commit_op(4'd1, 1'b0);
    while (!issue_ready_o && k < 5) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (issue_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_ready_return: got %0b, required 1", issue_ready_o);
    end
    wait_results("full");
    flush_cycle();
  endtask

  task automatic test_kill();
    issue_op("kill_a", mk_instr(7'h22, 3'h3, 7'b0001011), 4'd1, 32'd100, 32'd1, 1'b1, 1'b1, 1'b0);
    issue_op("kill_b", mk_instr(7'h23, 3'h4, 7'b0001011), 4'd2, 32'd200, 32'd22, 1'b1, 1'b1, 1'b0);
    commit_op(4'd1, 1'b1);
    push_op({7'h23, 3'h4}, 32'd200, 32'd22, 4'd2, 1'b1);
    commit_op(4'd2, 1'b0);
    wait_results("kill");
    quiet_window("kill_after", 8);
  endtask

  task automatic test_flush();
    issue_op("flush_a", mk_instr(7'h31, 3'h5, 7'b0001011), 4'd5, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
    push_op({7'h31, 3'h5}, 32'd9, 32'd9, 4'd5, 1'b0);
    issue_op("flush_b", mk_instr(7'h32, 3'h6, 7'b0001011), 4'd7, 32'd70, 32'd7, 1'b1, 1'b1, 1'b0);
    wait_start("flush");
    @(posedge clk); #1;
    flush_cycle();
    quiet_window("flush_drop", LAT + 5);
    commit_op(4'd7, 1'b0);
    quiet_window("flush_empty", 6);
    issue_op("flush_next", mk_instr(7'h33, 3'h7, 7'b0001011), 4'd6, 32'd60, 32'd6, 1'b1, 1'b1, 1'b1);
    push_op({7'h33, 3'h7}, 32'd60, 32'd6, 4'd6, 1'b1);
    wait_results("flush");
  endtask

  task automatic test_back_to_back();
    int k = 0;
    logic stable = 1'b1;
    result_ready_i = 1'b0;
    issue_op("b2b_a", mk_instr(7'h41, 3'h1, 7'b0001011), 4'd8, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
    push_op({7'h41, 3'h1}, 32'd3, 32'd4, 4'd8, 1'b1);
    issue_op("b2b_b", mk_instr(7'h42, 3'h2, 7'b0001011), 4'd10, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1);
    push_op({7'h42, 3'h2}, 32'd1, 32'd1, 4'd10, 1'b1);
    while (!result_valid_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (result_valid_o !== 1'b1 || result_id_o !== 4'd8 || result_data_o !== 32'd7 || acc_start_o !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold: got valid=%0b id=%0d data=%0d start=%0b, required 1 8 7 0",
               result_valid_o, result_id_o, result_data_o, acc_start_o);
    end
    result_ready_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (acc_start_o !== 1'b1 || result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: got start=%0b valid=%0b, required 1 0", acc_start_o, result_valid_o);
    end
    wait_results("b2b");
  endtask

  task automatic test_reset_mid_op();
    issue_op("rst_op", mk_instr(7'h51, 3'h3, 7'b0001011), 4'd9, 32'd2, 32'd2, 1'b1, 1'b1, 1'b1);
    push_op({7'h51, 3'h3}, 32'd2, 32'd2, 4'd9, 1'b0);
    wait_start("rst");
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    total++;
    if (acc_a_o !== '0 || acc_funct_o !== '0 || result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_values: got a=%0d funct=%h valid=%0b ready=%0b, required 0 0 0 1",
               acc_a_o, acc_funct_o, result_valid_o, issue_ready_o);
    end
    @(posedge clk); #1;
    rst_i     = 1'b0;
    stale_req = 1'b1;
    quiet_window("rst_stale_done", 8);
    issue_op("rst_next", mk_instr(7'h52, 3'h4, 7'b0001011), 4'd11, 32'd40, 32'd2, 1'b1, 1'b1, 1'b1);
    push_op({7'h52, 3'h4}, 32'd40, 32'd2, 4'd11, 1'b1);
    wait_results("rst");
  endtask

  initial begin
    rst_i          = 1'b1;
    issue_valid_i  = 1'b0;
    issue_instr_i  = '0;
    issue_id_i     = '0;
    issue_rs1_i    = '0;
    issue_rs2_i    = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    flush_i        = 1'b0;
    acc_done_i     = 1'b0;
    acc_result_i   = '0;
    result_ready_i = 1'b1;
    test_reset();
    test_single_op();
    test_non_accel();
    test_full();
    test_kill();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
